sdram_device_model: RTL and testbench

- Cycle-based single-rank SDR SDRAM device model, parameterisable for x8, x16 and x32 organisations.
- Sits on the far side of the SDRAM pins as the memory the SDRAM controller drives.
- Decodes JEDEC SDR commands, holds per-bank open-row state, a mode register and a storage array.
- Executes burst reads and writes on a bidirectional data bus with DQM byte masking.

---
 rtl/sdram_device_model.sv | 211 +++++++++++++++++++++
 tb/tb_sdram_device_model.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_model.sv
// Cycle-based single-rank SDR SDRAM device model (x8/x16/x32).
// Decodes SDR commands, tracks per-bank open rows and the mode register,
// and serves burst reads/writes on a tristate dq bus with DQM byte masking.
module sdram_device_model #(
  parameter int DATA_BITS      = 16,
  parameter int DM_BITS        = DATA_BITS / 8,
  parameter int ADDR_BITS      = 12,
  parameter int COL_BITS       = 8,
  parameter int STORE_ROW_BITS = 6
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [1:0]           ba,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DM_BITS-1:0]   dqm,
  inout  wire  [DATA_BITS-1:0] dq
);

  localparam int MEM_AW = 2 + STORE_ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  // Burst length code to (length - 1); undefined codes behave as BL1.
  function automatic logic [2:0] bl_mask(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd1;
      3'b010:  return 3'd3;
      3'b011:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Column of beat k: only the low log2(BL) bits move, wrapping inside the block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] c,
                                                   input logic [2:0] k,
                                                   input logic [2:0] m,
                                                   input logic il);
    logic [COL_BITS-1:0] mk, kk, low;
    mk  = COL_BITS'(m);
    kk  = COL_BITS'(k);
    low = il ? (c ^ kk) : (c + kk);
    return (c & ~mk) | (low & mk);
  endfunction

  logic [DATA_BITS-1:0]      mem [DEPTH];
  logic [3:0]                bank_open;
  logic [STORE_ROW_BITS-1:0] open_row [4];

  logic [2:0] mode_bl;
  logic       mode_il;
  logic       mode_cl2;
  logic       mode_wr_single;

  logic                burst_on;
  logic                burst_wr;
  logic                burst_ap;
  logic [1:0]          burst_bank;
  logic [COL_BITS-1:0] burst_col;
  logic [2:0]          burst_k;
  logic [2:0]          burst_mask;
  logic                ap_pend;
  logic [1:0]          ap_bank;

  logic                 vld_p0, vld_p1;
  logic [DATA_BITS-1:0] data_p0, data_p1, dout;
  logic [DM_BITS-1:0]   dqm_p0;
  logic [DM_BITS-1:0]   oe;

  logic [2:0]          cmd;
  logic                cmd_sel, rd_cmd, wr_cmd, rw_cmd, stop_cmd, eng_beat;
  logic                beat_go, beat_wr, wr_en;
  logic [1:0]          beat_bank;
  logic [COL_BITS-1:0] beat_c;
  logic [2:0]          cmd_mask;
  logic [MEM_AW-1:0]   beat_addr;
  logic [DATA_BITS-1:0] rd_word, wr_word;
  logic                unused_addr;

  assign unused_addr = ^addr;

  assign cmd      = {ras_n, cas_n, we_n};
  assign cmd_sel  = cke && !cs_n;
  assign rd_cmd   = cmd_sel && (cmd == CMD_RD) && bank_open[ba];
  assign wr_cmd   = cmd_sel && (cmd == CMD_WR) && bank_open[ba];
  assign rw_cmd   = rd_cmd || wr_cmd;
  assign stop_cmd = cmd_sel && ((cmd == CMD_BST) ||
                    ((cmd == CMD_PRE) && (addr[10] || (ba == burst_bank))));
  assign eng_beat = cke && burst_on && !rw_cmd && !stop_cmd;
  assign cmd_mask = (wr_cmd && mode_wr_single) ? 3'd0 : bl_mask(mode_bl);

  // A new command supplies beat 0 itself; otherwise the burst engine supplies beat k.
  assign beat_go   = rw_cmd || eng_beat;
  assign beat_wr   = rw_cmd ? wr_cmd : burst_wr;
  assign beat_bank = rw_cmd ? ba : burst_bank;
  assign beat_c    = rw_cmd ? addr[COL_BITS-1:0]
                            : beat_col(burst_col, burst_k, burst_mask, mode_il);
  assign beat_addr = {beat_bank, open_row[beat_bank], beat_c};
  assign rd_word   = mem[beat_addr];
  assign wr_en     = sdram_resetn && beat_go && beat_wr;

  // Byte-masked write data: masked lanes keep the stored byte.
  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < DM_BITS; i++)
      if (!dqm[i]) wr_word[8*i +: 8] = dq[8*i +: 8];
  end

  // Storage array; never cleared by reset.
  always_ff @(posedge sdram_clk) begin
    if (wr_en) mem[beat_addr] <= wr_word;
  end

  // Bank state, mode register, burst engine and read-pipeline control.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      bank_open      <= '0;
      mode_bl        <= 3'b000;
      mode_il        <= 1'b0;
      mode_cl2       <= 1'b0;
      mode_wr_single <= 1'b0;
      burst_on       <= 1'b0;
      ap_pend        <= 1'b0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      dqm_p0         <= '0;
      oe             <= '0;
    end else if (cke) begin
      if (ap_pend) bank_open[ap_bank] <= 1'b0;
      ap_pend <= 1'b0;

      if (cmd_sel) begin
        case (cmd)
          CMD_ACT: if (!bank_open[ba]) begin
            bank_open[ba] <= 1'b1;
            open_row[ba]  <= addr[STORE_ROW_BITS-1:0];
          end
          CMD_PRE: if (addr[10]) bank_open <= '0;
                   else          bank_open[ba] <= 1'b0;
          CMD_MRS: if ((bank_open == 4'b0000) && !burst_on) begin
            mode_bl        <= addr[2:0];
            mode_il        <= addr[3];
            mode_cl2       <= (addr[6:4] == 3'b010);
            mode_wr_single <= addr[9];
          end
          CMD_REF: ;
          default: ;
        endcase
      end

      if (rw_cmd) begin
        burst_wr   <= wr_cmd;
        burst_bank <= ba;
        burst_col  <= addr[COL_BITS-1:0];
        burst_ap   <= addr[10];
        burst_mask <= cmd_mask;
        burst_k    <= 3'd1;
        burst_on   <= (cmd_mask != 3'd0);
        ap_pend    <= addr[10] && (cmd_mask == 3'd0);
        ap_bank    <= ba;
      end else if (stop_cmd) begin
        burst_on <= 1'b0;
      end else if (burst_on) begin
        if (burst_k == burst_mask) begin
          burst_on <= 1'b0;
          ap_pend  <= burst_ap;
          ap_bank  <= burst_bank;
        end else begin
          burst_k <= burst_k + 3'd1;
        end
      end

      // A WRITE drops queued read beats and releases the bus at once.
      if (wr_cmd) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
        oe     <= '0;
      end else begin
        vld_p0 <= beat_go && !beat_wr && !mode_cl2;
        vld_p1 <= mode_cl2 ? (beat_go && !beat_wr) : vld_p0;
        oe     <= vld_p1 ? ~dqm_p0 : '0;
      end
      dqm_p0 <= dqm;
    end
  end

  // Read data path: CL2 enters at stage 1, CL3 at stage 0.
  always_ff @(posedge sdram_clk) begin
    if (cke) begin
      data_p0 <= rd_word;
      data_p1 <= mode_cl2 ? rd_word : data_p0;
      dout    <= data_p1;
    end
  end

  for (genvar i = 0; i < DM_BITS; i++) begin : g_dq
    assign dq[8*i +: 8] = oe[i] ? dout[8*i +: 8] : 8'bz;
  end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed testbench for sdram_device_model (x16). dq carries a pull-up so a
// released bus reads as all ones; driven test words never contain 0xFF bytes.
module tb_sdram_device_model;

  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] PRE = 3'b010, MRS = 3'b000, BST = 3'b110;
  localparam logic [15:0] HIZ = 16'hFFFF;

  logic        clk = 1'b0;
  logic        resetn, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [1:0]  dqm;
  logic [15:0] drv_data;
  logic        drv_en;
  tri1  [15:0] dq;

  int n_cmp = 0;
  int n_err = 0;

  assign dq = drv_en ? drv_data : 16'hzzzz;

  sdram_device_model dut (
    .sdram_clk(clk), .sdram_resetn(resetn), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .dqm(dqm), .dq(dq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // After step() returns, dq shows the value the controller samples at the next edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a;
    step();
    cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
  endtask

  task automatic wr4(input logic [1:0] b, input logic [11:0] a,
                     input logic [15:0] w0, w1, w2, w3);
    drv_en = 1'b1; drv_data = w0; issue(WR, b, a);
    drv_data = w1; step();
    drv_data = w2; step();
    drv_data = w3; step();
    drv_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; step(); step();
    resetn = 1'b1; step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL reset_hiz: got %h required %h", dq, HIZ); end
  endtask

  task automatic test_basic_burst();
    logic [15:0] exp [7];
    exp = '{HIZ, HIZ, 16'h1111, 16'h2222, 16'h3333, 16'h4444, HIZ};
    issue(MRS, 2'd0, 12'h032);
    issue(ACT, 2'd1, 12'd5);
    wr4(2'd1, 12'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    issue(RD, 2'd1, 12'h010);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (dq !== exp[i]) begin
        n_err++; $display("FAIL basic_read T+%0d: got %h required %h", i + 1, dq, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_write_mask();
    logic [15:0] exp [3];
    exp = '{HIZ, 16'h11CD, HIZ};
    issue(PRE, 2'd0, 12'h400);
    issue(MRS, 2'd0, 12'h020);
    issue(ACT, 2'd1, 12'd5);
    dqm = 2'b10; drv_en = 1'b1; drv_data = 16'hABCD;
    issue(WR, 2'd1, 12'h010);
    dqm = 2'b00; drv_data = 16'h5A5A; step();
    drv_en = 1'b0;
    issue(RD, 2'd1, 12'h010);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dq !== exp[i]) begin
        n_err++; $display("FAIL mask_read T+%0d: got %h required %h", i + 1, dq, exp[i]);
      end
      step();
    end
    issue(RD, 2'd1, 12'h011);
    step();
    n_cmp++;
    if (dq !== 16'h2222) begin
      n_err++; $display("FAIL bl1_write_only_one: got %h required %h", dq, 16'h2222);
    end
    step(); step();
  endtask

  task automatic test_wrap();
    logic [15:0] seq_exp [4];
    logic [15:0] il_exp [4];
    seq_exp = '{16'h3333, 16'h4444, 16'h11CD, 16'h2222};
    il_exp  = '{16'h1A01, 16'h1A00, 16'h1A03, 16'h1A02};
    issue(PRE, 2'd0, 12'h400);
    issue(MRS, 2'd0, 12'h032);
    issue(ACT, 2'd1, 12'd5);
    wr4(2'd1, 12'h000, 16'h1A00, 16'h1A01, 16'h1A02, 16'h1A03);
    issue(RD, 2'd1, 12'h012);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dq !== seq_exp[i]) begin
        n_err++; $display("FAIL seq_wrap beat%0d: got %h required %h", i, dq, seq_exp[i]);
      end
      step();
    end
    issue(PRE, 2'd0, 12'h400);
    issue(MRS, 2'd0, 12'h03A);
    issue(ACT, 2'd1, 12'd5);
    issue(RD, 2'd1, 12'h001);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dq !== il_exp[i]) begin
        n_err++; $display("FAIL interleave beat%0d: got %h required %h", i, dq, il_exp[i]);
      end
      step();
    end
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL interleave_end: got %h required %h", dq, HIZ); end
  endtask

  task automatic test_precharge();
    issue(PRE, 2'd0, 12'h400);
    issue(RD, 2'd0, 12'h010);
    issue(RD, 2'd1, 12'h010);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (dq !== HIZ) begin
        n_err++; $display("FAIL read_idle_bank cyc%0d: got %h required %h", i, dq, HIZ);
      end
      step();
    end
    issue(ACT, 2'd1, 12'd5);
    issue(RD, 2'd1, 12'h410);
    step(); step();
    n_cmp++;
    if (dq !== 16'h11CD) begin n_err++; $display("FAIL ap_beat0: got %h required %h", dq, 16'h11CD); end
    step();
    n_cmp++;
    if (dq !== 16'h2222) begin n_err++; $display("FAIL ap_beat1: got %h required %h", dq, 16'h2222); end
    step();
    n_cmp++;
    if (dq !== 16'h3333) begin n_err++; $display("FAIL ap_beat2: got %h required %h", dq, 16'h3333); end
    issue(RD, 2'd1, 12'h010);
    n_cmp++;
    if (dq !== 16'h4444) begin n_err++; $display("FAIL ap_beat3: got %h required %h", dq, 16'h4444); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (dq !== HIZ) begin
        n_err++; $display("FAIL read_after_ap cyc%0d: got %h required %h", i, dq, HIZ);
      end
    end
  endtask

  task automatic test_burst_terminate();
    issue(PRE, 2'd0, 12'h400);
    issue(MRS, 2'd0, 12'h033);
    issue(ACT, 2'd1, 12'd5);
    issue(RD, 2'd1, 12'h010);
    step(); step();
    n_cmp++;
    if (dq !== 16'h11CD) begin n_err++; $display("FAIL bst_beat0: got %h required %h", dq, 16'h11CD); end
    step();
    n_cmp++;
    if (dq !== 16'h2222) begin n_err++; $display("FAIL bst_beat1: got %h required %h", dq, 16'h2222); end
    issue(BST, 2'd0, 12'h000);
    n_cmp++;
    if (dq !== 16'h3333) begin n_err++; $display("FAIL bst_beat2: got %h required %h", dq, 16'h3333); end
    step();
    n_cmp++;
    if (dq !== 16'h4444) begin n_err++; $display("FAIL bst_beat3: got %h required %h", dq, 16'h4444); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (dq !== HIZ) begin
        n_err++; $display("FAIL bst_after cyc%0d: got %h required %h", i, dq, HIZ);
      end
    end
  endtask

  task automatic test_dqm_read();
    issue(RD, 2'd1, 12'h010);
    step(); step();
    n_cmp++;
    if (dq !== 16'h11CD) begin n_err++; $display("FAIL dqm_beat0: got %h required %h", dq, 16'h11CD); end
    dqm = 2'b01; step();
    n_cmp++;
    if (dq !== 16'h2222) begin n_err++; $display("FAIL dqm_beat1: got %h required %h", dq, 16'h2222); end
    dqm = 2'b00; step();
    n_cmp++;
    if (dq !== 16'h33FF) begin n_err++; $display("FAIL dqm_masked: got %h required %h", dq, 16'h33FF); end
    step();
    n_cmp++;
    if (dq !== 16'h4444) begin n_err++; $display("FAIL dqm_beat3: got %h required %h", dq, 16'h4444); end
    issue(BST, 2'd0, 12'h000);
    step(); step(); step();
  endtask

  task automatic test_reset_mid_read();
    issue(RD, 2'd1, 12'h010);
    step(); step();
    n_cmp++;
    if (dq !== 16'h11CD) begin n_err++; $display("FAIL rst_beat0: got %h required %h", dq, 16'h11CD); end
    resetn = 1'b0; step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL rst_release: got %h required %h", dq, HIZ); end
    resetn = 1'b1; step(); step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL rst_stays_hiz: got %h required %h", dq, HIZ); end
    issue(RD, 2'd1, 12'h012);
    step(); step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL rst_bank_idle: got %h required %h", dq, HIZ); end
    step(); step();
    issue(ACT, 2'd1, 12'd5);
    issue(RD, 2'd1, 12'h012);
    step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL rst_cl3_early: got %h required %h", dq, HIZ); end
    step();
    n_cmp++;
    if (dq !== 16'h3333) begin n_err++; $display("FAIL rst_data_kept: got %h required %h", dq, 16'h3333); end
    step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL rst_bl1: got %h required %h", dq, HIZ); end
    step(); step();
  endtask

  task automatic test_cke_hold();
    issue(RD, 2'd1, 12'h013);
    cke = 1'b0; step();
    cke = 1'b1;
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL cke_t2: got %h required %h", dq, HIZ); end
    step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL cke_t3: got %h required %h", dq, HIZ); end
    step();
    n_cmp++;
    if (dq !== 16'h4444) begin n_err++; $display("FAIL cke_t4: got %h required %h", dq, 16'h4444); end
    step();
    n_cmp++;
    if (dq !== HIZ) begin n_err++; $display("FAIL cke_t5: got %h required %h", dq, HIZ); end
  endtask

  initial begin
    resetn = 1'b0; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
    ba = 2'd0; addr = 12'd0; dqm = 2'b00; drv_en = 1'b0; drv_data = 16'h0000;
    @(negedge clk);
    test_reset();
    test_basic_burst();
    test_write_mask();
    test_wrap();
    test_precharge();
    test_burst_terminate();
    test_dqm_read();
    test_reset_mid_read();
    test_cke_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
